dat_mem_arbiter: RTL and testbench
==================================

DAT_MEM_ARBITER -- requirements
Module: dat_mem_arbiter

Interface
REQ-001 The module SHALL have parameter FAIR, default 4, meaning core-only cycles after each host burst (legal range 1..15).
REQ-002 The module SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 The module SHALL have ports core_rd / core_wr  in  1 each  core load/store strobes (RdMem/WrMem).
REQ-005 The module SHALL have ports core_addr / core_wdata  in  8 each  core memory address and store data.
REQ-006 The module SHALL have ports core_rdata  out  8  load data to core; core_stall  out  1  core must hold PC and strobes.
REQ-007 The module SHALL have ports host_req  in  1; host_wr  in  1; host_base  in  8; host_len  in  4 (beats-1); host_wdata  in  8.
REQ-008 The module SHALL have ports host_gnt  out  1; host_valid  out  1; host_rdata  out  8; host_done  out  1.
REQ-009 The module SHALL have ports mem_addr  out  8; mem_wdata  out  8; mem_wr_en  out  1; mem_rdata  in  8 (combinational-read, clocked-write 256x8 memory).

Function
REQ-010 The FSM SHALL have states IDLE, BURST, COOL; IDLE->BURST when host_req=1 in IDLE; BURST->COOL on edge ending the last beat; COOL->IDLE after FAIR cycles in COOL.
REQ-011 host_gnt SHALL equal host_req in IDLE (reset deasserted), else 0; host_wr, host_base, host_len SHALL be latched on the edge leaving IDLE.
REQ-012 BURST SHALL last exactly host_len+1 cycles, one beat per cycle, beat counter 0..host_len.
REQ-013 In BURST: mem_addr = latched base + beat, modulo 256 (0xFF wraps to 0x00); host_valid=1; host_rdata = mem_rdata; mem_wdata = host_wdata; mem_wr_en = latched host_wr.
REQ-014 In BURST: core_stall = core_rd | core_wr; core writes SHALL NOT reach memory; core_rdata SHALL be 0.
REQ-015 In IDLE and COOL: mem_addr = core_addr, mem_wdata = core_wdata, mem_wr_en = core_wr, core_rdata = mem_rdata, core_stall=0, host_valid=0, host_rdata=0.
REQ-016 host_done SHALL pulse high for exactly the first COOL cycle.
REQ-017 host_req SHALL be ignored in BURST and COOL; a held request SHALL be granted in the first IDLE cycle after COOL.
REQ-018 host_req=1 and core access in the same IDLE cycle: core access SHALL complete that cycle; burst starts next cycle.
REQ-019 Changes on host_base/host_len/host_wr during BURST SHALL NOT affect the burst in progress.
REQ-020 core_rd and core_wr both 1 SHALL be treated as a write (mem_wr_en=1) with core_rdata = mem_rdata.

Reset
REQ-021 With reset=0 at a rising edge, the FSM SHALL enter IDLE, zero beat and FAIR counters and latched host fields, from any state including mid-BURST.
REQ-022 While reset=0: host_gnt=0, host_valid=0, host_done=0, core_stall=0, mem_wr_en=0, host_rdata=0, core_rdata=0, mem_addr=0, mem_wdata=0.
REQ-023 A burst aborted by reset SHALL NOT produce host_done; beats written before reset SHALL remain in memory.

Verification
REQ-024 Core-only: core_wr addr 0x10 data 0x5A, then core_rd 0x10 -> core_rdata=0x5A, core_stall never 1.
REQ-025 Host write burst: host_req, base 0x20, len 3, wr=1, wdata 1,2,3,4 per beat -> 4 host_valid cycles, mem[0x20..0x23]=1..4, host_done in following cycle, then 4 cycles core-only.
REQ-026 Wrap: host read burst base 0xFE, len 2 -> mem_addr 0xFE, 0xFF, 0x00; host_rdata matches preloaded values.
REQ-027 Contention: core_wr to 0x30 during BURST -> core_stall=1 each such cycle, mem[0x30] unchanged until core retries in COOL.
REQ-028 Held host_req across burst end -> no grant during FAIR=4 COOL cycles; host_gnt=1 on 5th cycle after host_done asserts.
REQ-029 Reset at beat 1 of a 4-beat write burst -> IDLE next cycle, host_done never asserted, only beat 0 written.

Source files
------------

// File: rtl/dat_mem_arbiter_if.sv
// Core/host/memory bundle for the data-memory arbiter.
// master drives the strobes and memory data; slave is the arbiter.
interface dat_mem_arbiter_if;
    logic       core_rd;
    logic       core_wr;
    logic [7:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       core_stall;

    logic       host_req;
    logic       host_wr;
    logic [7:0] host_base;
    logic [3:0] host_len;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_valid;
    logic [7:0] host_rdata;
    logic       host_done;

    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr_en;
    logic [7:0] mem_rdata;

    modport master (
        output core_rd, core_wr, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output host_req, host_wr, host_base, host_len, host_wdata,
        input  host_gnt, host_valid, host_rdata, host_done,
        input  mem_addr, mem_wdata, mem_wr_en,
        output mem_rdata
    );

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  host_req, host_wr, host_base, host_len, host_wdata,
        output host_gnt, host_valid, host_rdata, host_done,
        output mem_addr, mem_wdata, mem_wr_en,
        input  mem_rdata
    );
endinterface

// File: rtl/dat_mem_arbiter.sv
// Shares one 256x8 data memory between the core and a host burst port.
// A host burst is followed by FAIR core-only cycles before the next grant.
module dat_mem_arbiter #(
    parameter int unsigned FAIR = 4
) (
    input  logic              clk,
    input  logic              reset,
    dat_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        COOL  = 2'd2
    } state_e;

    localparam logic [3:0] FAIR_M1 = 4'(FAIR - 1);

    state_e     state_q, state_d;
    logic [3:0] beat_q,  beat_d;
    logic [3:0] cool_q,  cool_d;
    logic       wr_q,    wr_d;
    logic [7:0] base_q,  base_d;
    logic [3:0] len_q,   len_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cool_q  <= '0;
            wr_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cool_q  <= cool_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cool_d  = cool_q;
        wr_d    = wr_q;
        base_d  = base_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (bus.host_req) begin
                    state_d = BURST;
                    beat_d  = '0;
                    wr_d    = bus.host_wr;
                    base_d  = bus.host_base;
                    len_d   = bus.host_len;
                end
            end
            BURST: begin
                if (beat_q == len_q) begin
                    state_d = COOL;
                    beat_d  = '0;
                    cool_d  = '0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            COOL: begin
                if (cool_q == FAIR_M1) begin
                    state_d = IDLE;
                    cool_d  = '0;
                end else begin
                    cool_d = cool_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the state.
    always_comb begin
        bus.core_rdata = '0;
        bus.core_stall = 1'b0;
        bus.host_gnt   = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_rdata = '0;
        bus.host_done  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wr_en  = 1'b0;
        if (reset) begin
            if (state_q == BURST) begin
                bus.mem_addr   = base_q + {4'b0, beat_q};
                bus.mem_wdata  = bus.host_wdata;
                bus.mem_wr_en  = wr_q;
                bus.host_valid = 1'b1;
                bus.host_rdata = bus.mem_rdata;
                bus.core_stall = bus.core_rd | bus.core_wr;
            end else begin
                bus.mem_addr   = bus.core_addr;
                bus.mem_wdata  = bus.core_wdata;
                bus.mem_wr_en  = bus.core_wr;
                bus.core_rdata = bus.mem_rdata;
                bus.host_gnt   = (state_q == IDLE) & bus.host_req;
                bus.host_done  = (state_q == COOL) & (cool_q == 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed vector bench for dat_mem_arbiter with FAIR=4 and a
// behavioural 256x8 memory attached to the mem_* port.
module tb_dat_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dat_mem_arbiter_if bus ();

    dat_mem_arbiter #(.FAIR(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'hFE] <= 8'hA1;
            mem[8'hFF] <= 8'hB2;
            mem[8'h00] <= 8'hC3;
            mem[8'h30] <= 8'h77;
            mem_ready  <= 1'b1;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    typedef struct {
        logic       rst;
        logic       crd;
        logic       cwr;
        logic [7:0] caddr;
        logic [7:0] cwd;
        logic       hreq;
        logic       hwr;
        logic [7:0] hbase;
        logic [3:0] hlen;
        logic [7:0] hwd;
        logic       stall;
        logic       gnt;
        logic       valid;
        logic       done;
        logic       wen;
        logic [7:0] maddr;
        logic [7:0] crdata;
        logic [7:0] hrdata;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    int errors = 0;
    int checks = 0;

    function automatic vec_t v(
        logic rst, logic crd, logic cwr, logic [7:0] caddr, logic [7:0] cwd,
        logic hreq, logic hwr, logic [7:0] hbase, logic [3:0] hlen,
        logic [7:0] hwd, logic stall, logic gnt, logic valid, logic done,
        logic wen, logic [7:0] maddr, logic [7:0] crdata, logic [7:0] hrdata);
        vec_t r;
        r.rst = rst;     r.crd = crd;       r.cwr = cwr;
        r.caddr = caddr; r.cwd = cwd;       r.hreq = hreq;
        r.hwr = hwr;     r.hbase = hbase;   r.hlen = hlen;
        r.hwd = hwd;     r.stall = stall;   r.gnt = gnt;
        r.valid = valid; r.done = done;     r.wen = wen;
        r.maddr = maddr; r.crdata = crdata; r.hrdata = hrdata;
        return r;
    endfunction

    task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        reset          = t.rst;
        bus.core_rd    = t.crd;
        bus.core_wr    = t.cwr;
        bus.core_addr  = t.caddr;
        bus.core_wdata = t.cwd;
        bus.host_req   = t.hreq;
        bus.host_wr    = t.hwr;
        bus.host_base  = t.hbase;
        bus.host_len   = t.hlen;
        bus.host_wdata = t.hwd;
    endtask

    task automatic apply(vec_t t, int idx);
        @(negedge clk);
        drive(t);
        #2;
        chk("core_stall", idx, {7'b0, bus.core_stall}, {7'b0, t.stall});
        chk("host_gnt",   idx, {7'b0, bus.host_gnt},   {7'b0, t.gnt});
        chk("host_valid", idx, {7'b0, bus.host_valid}, {7'b0, t.valid});
        chk("host_done",  idx, {7'b0, bus.host_done},  {7'b0, t.done});
        chk("mem_wr_en",  idx, {7'b0, bus.mem_wr_en},  {7'b0, t.wen});
        chk("mem_addr",   idx, bus.mem_addr,   t.maddr);
        chk("core_rdata", idx, bus.core_rdata, t.crdata);
        chk("host_rdata", idx, bus.host_rdata, t.hrdata);
    endtask

    initial begin
        vec_t idle;
        reset          = 1'b0;
        bus.core_rd    = 1'b0;
        bus.core_wr    = 1'b0;
        bus.core_addr  = 8'h00;
        bus.core_wdata = 8'h00;
        bus.host_req   = 1'b0;
        bus.host_wr    = 1'b0;
        bus.host_base  = 8'h00;
        bus.host_len   = 4'd0;
        bus.host_wdata = 8'h00;

        // reset gating, then core-only traffic
        tbl[0]  = v(0,1,1,8'h10,8'h5A, 1,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h00,8'h00,8'h00);
        tbl[1]  = v(1,0,1,8'h10,8'h5A, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,1,8'h10,8'h00,8'h00);
        tbl[2]  = v(1,1,0,8'h10,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h10,8'h5A,8'h00);
        tbl[3]  = v(1,1,1,8'h11,8'h33, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,1,8'h11,8'h00,8'h00);
        tbl[4]  = v(1,1,0,8'h11,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h11,8'h33,8'h00);
        // host write burst 0x20 len 3, core store in the grant cycle
        tbl[5]  = v(1,0,1,8'h12,8'h44, 1,1,8'h20,4'd3,8'h01, 0,1,0,0,1,8'h12,8'h00,8'h00);
        tbl[6]  = v(1,0,0,8'h00,8'h00, 0,0,8'h99,4'd0,8'h01, 0,0,1,0,1,8'h20,8'h00,8'h00);
        tbl[7]  = v(1,0,1,8'h30,8'hEE, 0,0,8'h99,4'd0,8'h02, 1,0,1,0,1,8'h21,8'h00,8'h00);
        tbl[8]  = v(1,1,0,8'h30,8'h00, 0,0,8'h99,4'd0,8'h03, 1,0,1,0,1,8'h22,8'h00,8'h00);
        tbl[9]  = v(1,0,0,8'h00,8'h00, 1,0,8'h99,4'd0,8'h04, 0,0,1,0,1,8'h23,8'h00,8'h00);
        // cool-down with held request; core retries its store
        tbl[10] = v(1,1,0,8'h20,8'h00, 1,0,8'h99,4'd0,8'h00, 0,0,0,1,0,8'h20,8'h01,8'h00);
        tbl[11] = v(1,1,0,8'h23,8'h00, 1,0,8'h99,4'd0,8'h00, 0,0,0,0,0,8'h23,8'h04,8'h00);
        tbl[12] = v(1,0,1,8'h30,8'hEE, 1,0,8'h99,4'd0,8'h00, 0,0,0,0,1,8'h30,8'h77,8'h00);
        tbl[13] = v(1,1,0,8'h30,8'h00, 1,0,8'h99,4'd0,8'h00, 0,0,0,0,0,8'h30,8'hEE,8'h00);
        // held request granted; wrapping read burst 0xFE len 2
        tbl[14] = v(1,0,0,8'h00,8'h00, 1,0,8'hFE,4'd2,8'h00, 0,1,0,0,0,8'h00,8'hC3,8'h00);
        tbl[15] = v(1,0,0,8'h00,8'h00, 0,1,8'h00,4'd0,8'h00, 0,0,1,0,0,8'hFE,8'h00,8'hA1);
        tbl[16] = v(1,0,0,8'h00,8'h00, 0,1,8'h00,4'd0,8'h00, 0,0,1,0,0,8'hFF,8'h00,8'hB2);
        tbl[17] = v(1,0,0,8'h00,8'h00, 0,1,8'h00,4'd0,8'h00, 0,0,1,0,0,8'h00,8'h00,8'hC3);
        tbl[18] = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,1,0,8'h00,8'hC3,8'h00);
        tbl[19] = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h00,8'hC3,8'h00);
        tbl[20] = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h00,8'hC3,8'h00);
        tbl[21] = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h00,8'hC3,8'h00);
        // write burst 0x40 aborted by reset at beat 1
        tbl[22] = v(1,0,0,8'h00,8'h00, 1,1,8'h40,4'd3,8'h11, 0,1,0,0,0,8'h00,8'hC3,8'h00);
        tbl[23] = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h11, 0,0,1,0,1,8'h40,8'h00,8'h00);
        tbl[24] = v(0,1,1,8'h55,8'h66, 0,0,8'h00,4'd0,8'h22, 0,0,0,0,0,8'h00,8'h00,8'h00);
        tbl[25] = v(1,1,0,8'h40,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h40,8'h11,8'h00);
        tbl[26] = v(1,1,0,8'h12,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h12,8'h44,8'h00);

        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) apply(tbl[i], i);

        // after the abort: no late done, no grant, no beats
        idle = v(1,0,0,8'h00,8'h00, 0,0,8'h00,4'd0,8'h00, 0,0,0,0,0,8'h00,8'h00,8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(idle);
            #2;
            chk("abort_done",  100 + i, {7'b0, bus.host_done},  8'h00);
            chk("abort_valid", 100 + i, {7'b0, bus.host_valid}, 8'h00);
        end

        chk("mem20", 200, mem[8'h20], 8'h01);
        chk("mem21", 201, mem[8'h21], 8'h02);
        chk("mem22", 202, mem[8'h22], 8'h03);
        chk("mem23", 203, mem[8'h23], 8'h04);
        chk("mem30", 204, mem[8'h30], 8'hEE);
        chk("mem40", 205, mem[8'h40], 8'h11);
        chk("mem41", 206, mem[8'h41], 8'h00);
        chk("mem55", 207, mem[8'h55], 8'h00);
        chk("mem99", 208, mem[8'h99], 8'h00);
        chk("memFE", 209, mem[8'hFE], 8'hA1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
